// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared store width and store FSM state types
package rv32i_types;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } store_state_t;

endpackage

// File: rtl/store_op_format.sv
// rtl/store_op_format.sv - combinational lane formatting and alignment check for stores
module store_op_format
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rs2_data,
    output logic [3:0]  byte_enable,
    output logic [31:0] wdata,
    output logic        legal
);

    always_comb begin
        byte_enable = 4'b0000;
        wdata       = 32'h0;
        legal       = 1'b0;
        case (funct3)
            SB: begin
                legal       = 1'b1;
                byte_enable = 4'b0001 << offset;
                wdata       = {4{rs2_data[7:0]}};
            end
            SH: begin
                legal       = ~offset[0];
                byte_enable = offset[1] ? 4'b1100 : 4'b0011;
                wdata       = {2{rs2_data[15:0]}};
            end
            SW: begin
                legal       = (offset == 2'b00);
                byte_enable = 4'b1111;
                wdata       = rs2_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_op_unit.sv
// rtl/store_op_unit.sv - store request FSM driving a single-beat memory write
module store_op_unit
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] rs2_data,
    input  logic        mem_resp,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_write,
    output logic        busy,
    output logic        done,
    output logic        store_err
);

    store_state_t state;
    logic [3:0]   fmt_be;
    logic [31:0]  fmt_wdata;
    logic         fmt_legal;

    store_op_format u_format (
        .funct3      (funct3),
        .offset      (addr[1:0]),
        .rs2_data    (rs2_data),
        .byte_enable (fmt_be),
        .wdata       (fmt_wdata),
        .legal       (fmt_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            mem_address     <= 32'h0;
            mem_wdata       <= 32'h0;
            mem_byte_enable <= 4'b0000;
            store_err       <= 1'b0;
        end else begin
            store_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (fmt_legal) begin
                            mem_address     <= {addr[31:2], 2'b00};
                            mem_wdata       <= fmt_wdata;
                            mem_byte_enable <= fmt_be;
                            state           <= ST_WRITE;
                        end else begin
                            store_err <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_resp) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Decoded from state so an async reset drops mem_write without waiting for a clock
    assign mem_write = (state == ST_WRITE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_store_op_unit.sv
// tb/tb_store_op_unit.sv - directed self-checking bench for store_op_unit
module tb_store_op_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] rs2_data;
    logic        mem_resp;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_write;
    logic        busy;
    logic        done;
    logic        store_err;

    int checks = 0;
    int errors = 0;

    store_op_unit dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .funct3          (funct3),
        .addr            (addr),
        .rs2_data        (rs2_data),
        .mem_resp        (mem_resp),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_write       (mem_write),
        .busy            (busy),
        .done            (done),
        .store_err       (store_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic mw, input logic bz, input logic dn, input logic er);
        check({tag, "_mem_write"}, {31'h0, mem_write}, {31'h0, mw});
        check({tag, "_busy"},      {31'h0, busy},      {31'h0, bz});
        check({tag, "_done"},      {31'h0, done},      {31'h0, dn});
        check({tag, "_store_err"}, {31'h0, store_err}, {31'h0, er});
    endtask

    task automatic check_bus(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        check({tag, "_addr"},  mem_address, a);
        check({tag, "_wdata"}, mem_wdata, d);
        check({tag, "_be"},    {28'h0, mem_byte_enable}, {28'h0, be});
    endtask

    task automatic request(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        start    = 1'b1;
        funct3   = f3;
        addr     = a;
        rs2_data = d;
        tick();
        start    = 1'b0;
        funct3   = 3'b111;
        addr     = 32'hFFFF_FFFF;
        rs2_data = 32'h0BAD_0BAD;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; funct3 = 3'b000; addr = 32'h0; rs2_data = 32'h0; mem_resp = 1'b0;
        #12;
        check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check_bus("reset", 32'h0, 32'h0, 4'b0000);
        tick();
        rst = 1'b0;
        tick();

        // SB at offset 3, memory holds off two cycles
        request(3'b000, 32'h0000_1003, 32'hDEAD_BEEF);
        check_ctl("sb_write", 1'b1, 1'b1, 1'b0, 1'b0);
        check_bus("sb_write", 32'h0000_1000, 32'hEFEF_EFEF, 4'b1000);
        tick();
        tick();
        check_ctl("sb_hold", 1'b1, 1'b1, 1'b0, 1'b0);
        check_bus("sb_hold", 32'h0000_1000, 32'hEFEF_EFEF, 4'b1000);
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        check_ctl("sb_done", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check_ctl("sb_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        request(3'b001, 32'h0000_2002, 32'h1234_5678);
        check_bus("sh_hi", 32'h0000_2000, 32'h5678_5678, 4'b1100);
        mem_resp = 1'b1; tick(); mem_resp = 1'b0;
        check_ctl("sh_done", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();

        request(3'b010, 32'h0000_2004, 32'hCAFE_F00D);
        check_bus("sw", 32'h0000_2004, 32'hCAFE_F00D, 4'b1111);
        mem_resp = 1'b1; tick(); mem_resp = 1'b0;
        check_ctl("sw_done", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();

        request(3'b001, 32'h0000_0001, 32'h1111_1111);
        check_ctl("err_sh", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_ctl("err_sh_clr", 1'b0, 1'b0, 1'b0, 1'b0);
        request(3'b010, 32'h0000_0006, 32'h2222_2222);
        check_ctl("err_sw", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        request(3'b011, 32'h0000_0000, 32'h3333_3333);
        check_ctl("err_f3", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_ctl("err_f3_clr", 1'b0, 1'b0, 1'b0, 1'b0);
        check_bus("err_nochg", 32'h0000_2004, 32'hCAFE_F00D, 4'b1111);

        // Slow memory with competing starts while busy
        request(3'b010, 32'h0000_3000, 32'hA5A5_5A5A);
        for (int i = 0; i < 5; i++) begin
            start    = (i == 1 || i == 3);
            funct3   = 3'b000;
            addr     = 32'h0000_4001;
            rs2_data = 32'h0000_0077;
            check_ctl("slow_hold", 1'b1, 1'b1, 1'b0, 1'b0);
            check_bus("slow_hold", 32'h0000_3000, 32'hA5A5_5A5A, 4'b1111);
            tick();
        end
        start = 1'b0;
        mem_resp = 1'b1; tick(); mem_resp = 1'b0;
        check_ctl("slow_done", 1'b0, 1'b1, 1'b1, 1'b0);
        check_bus("slow_done", 32'h0000_3000, 32'hA5A5_5A5A, 4'b1111);
        tick();
        check_ctl("slow_single_done", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_ctl("slow_no_second", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a write, then a stray response
        request(3'b000, 32'h0000_5002, 32'h0000_00C3);
        check_ctl("rst_pre", 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_ctl("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
        check_bus("rst_async", 32'h0, 32'h0, 4'b0000);
        tick();
        rst = 1'b0;
        mem_resp = 1'b1; tick(); mem_resp = 1'b0;
        check_ctl("rst_stray", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_ctl("rst_stray2", 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back SB with zero-wait memory: 3-cycle spacing
        request(3'b000, 32'h0000_0010, 32'h0000_0011);
        check_ctl("b2b_a", 1'b1, 1'b1, 1'b0, 1'b0);
        check_bus("b2b_a", 32'h0000_0010, 32'h1111_1111, 4'b0001);
        mem_resp = 1'b1; tick(); mem_resp = 1'b0;
        check_ctl("b2b_a_done", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check_ctl("b2b_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        request(3'b000, 32'h0000_0012, 32'h0000_00AB);
        check_ctl("b2b_b", 1'b1, 1'b1, 1'b0, 1'b0);
        check_bus("b2b_b", 32'h0000_0010, 32'hABAB_ABAB, 4'b0100);
        mem_resp = 1'b1; tick(); mem_resp = 1'b0;
        check_ctl("b2b_b_done", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check_ctl("b2b_end", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
